// File: rtl/conv_pool_channel_if.sv
// Stream and control bundle for conv_pool_channel.
// Holds weight load, config, pixel input and result output signals.
interface conv_pool_channel_if #(
  parameter int DATA_W   = 8,
  parameter int WEIGHT_W = 8,
  parameter int ACC_W    = 32
);
  logic                       w_valid;
  logic signed [WEIGHT_W-1:0] w_data;
  logic                       w_ready;
  logic                       w_reload;
  logic                       weights_loaded;
  logic signed [ACC_W-1:0]    cfg_bias;
  logic [4:0]                 cfg_shift;
  logic [1:0]                 cfg_pool_mode;
  logic                       start;
  logic                       in_valid;
  logic                       in_ready;
  logic signed [DATA_W-1:0]   pixel_in;
  logic                       out_valid;
  logic signed [DATA_W-1:0]   pixel_out;
  logic                       layer_done;

  modport master (
    output w_valid, w_data, w_reload,
    output cfg_bias, cfg_shift, cfg_pool_mode,
    output start, in_valid, pixel_in,
    input  w_ready, weights_loaded, in_ready,
    input  out_valid, pixel_out, layer_done
  );

  modport slave (
    input  w_valid, w_data, w_reload,
    input  cfg_bias, cfg_shift, cfg_pool_mode,
    input  start, in_valid, pixel_in,
    output w_ready, weights_loaded, in_ready,
    output out_valid, pixel_out, layer_done
  );
endinterface

// File: rtl/conv_pool_channel.sv
// Single-channel KxK conv, bias, requant/ReLU and 2x2 pool stage.
// Weights stream in at run time; pixels stream in raster order.
module conv_pool_channel #(
  parameter int MAP_W    = 32,
  parameter int MAP_H    = 32,
  parameter int K        = 5,
  parameter int DATA_W   = 8,
  parameter int WEIGHT_W = 8,
  parameter int ACC_W    = 32
) (
  input logic clk,
  input logic rst,
  conv_pool_channel_if.slave bus
);
  localparam int OW  = MAP_W - K + 1;
  localparam int PW  = (OW / 2 > 0) ? OW / 2 : 1;
  localparam int PJW = (PW > 1) ? $clog2(PW) : 1;
  localparam int CW  = $clog2(MAP_W);
  localparam int RW  = $clog2(MAP_H);
  localparam int KW  = $clog2(K);
  localparam int SW  = DATA_W + 2;
  localparam int PRW = WEIGHT_W + DATA_W;
  localparam logic KODD = 1'((K - 1) % 2);
  localparam logic signed [ACC_W-1:0] QMAX =
    ACC_W'(2 ** (DATA_W - 1) - 1);

  typedef enum logic [1:0] {LOAD, IDLE, RUN} state_t;
  state_t state, state_n;

  logic signed [WEIGHT_W-1:0] wt [K][K];
  logic [KW-1:0] wr, wc;
  logic [RW-1:0] r;
  logic [CW-1:0] c;
  logic in_done;
  logic signed [DATA_W-1:0] lb [K-1][MAP_W];
  logic signed [DATA_W-1:0] win [K][K];
  logic signed [DATA_W-1:0] col [K];
  logic signed [ACC_W-1:0] bias;
  logic [4:0] shift;
  logic byp, avg;

  logic v1, l1, ro1, co1;
  logic [PJW-1:0] pj1;
  logic v2, l2, ro2, co2;
  logic [PJW-1:0] pj2;
  logic signed [ACC_W-1:0] acc;
  logic v3, l3, ro3, co3;
  logic [PJW-1:0] pj3;
  logic [DATA_W-1:0] q3;
  logic v4, l4;
  logic [DATA_W-1:0] pq;
  logic [SW-1:0] hreg;
  logic [SW-1:0] pbuf [PW];

  logic w_acc, w_last, p_acc, p_last, done;
  logic signed [ACC_W-1:0] acc_n, scaled;
  logic signed [PRW-1:0] prod;
  logic [DATA_W-1:0] q_n, pool_n;
  logic [SW-1:0] qx, pair, prev, blk;

  assign w_acc  = bus.w_valid && bus.w_ready;
  assign w_last = (wr == KW'(K - 1)) && (wc == KW'(K - 1));
  assign p_acc  = bus.in_valid && bus.in_ready;
  assign p_last = (r == RW'(MAP_H - 1)) &&
                  (c == CW'(MAP_W - 1));

  assign bus.w_ready        = (state == LOAD);
  assign bus.weights_loaded = (state != LOAD);
  assign bus.in_ready       = (state == RUN) && !in_done;
  assign done               = byp ? (v3 && l3) : (v4 && l4);
  assign bus.out_valid      = byp ? v3 : v4;
  assign bus.pixel_out      = byp ? q3 : pq;
  assign bus.layer_done     = done;

  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      LOAD: if (w_acc && w_last) state_n = IDLE;
      IDLE: begin
        if (bus.start)         state_n = RUN;
        else if (bus.w_reload) state_n = LOAD;
      end
      RUN:  if (done) state_n = IDLE;
      default: state_n = LOAD;
    endcase
  end

  // New window column: oldest row on top, incoming pixel at the bottom
  always_comb begin
    col[K-1] = bus.pixel_in;
    for (int k = 0; k < K - 1; k++)
      col[K-2-k] = lb[k][c];
  end

  always_comb begin
    acc_n = bias;
    prod  = '0;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++) begin
        prod  = wt[i][j] * win[i][j];
        acc_n = acc_n + ACC_W'(prod);
      end
  end

  always_comb begin
    scaled = acc >>> shift;
    if (scaled < 0)
      q_n = '0;
    else if (scaled > QMAX)
      q_n = {1'b0, {(DATA_W-1){1'b1}}};
    else
      q_n = scaled[DATA_W-1:0];
  end

  // Pool partials hold a max or a running sum, depending on mode
  always_comb begin
    qx   = SW'(q3);
    pair = avg ? hreg + qx : ((hreg > qx) ? hreg : qx);
    prev = pbuf[pj3];
    blk  = avg ? prev + pair : ((prev > pair) ? prev : pair);
    pool_n = avg ? blk[DATA_W+1:2] : blk[DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr <= '0;
      wc <= '0;
      for (int i = 0; i < K; i++)
        for (int j = 0; j < K; j++) begin
          wt[i][j]  <= '0;
          win[i][j] <= '0;
        end
      for (int k = 0; k < K - 1; k++)
        for (int x = 0; x < MAP_W; x++)
          lb[k][x] <= '0;
      for (int p = 0; p < PW; p++) pbuf[p] <= '0;
      r <= '0; c <= '0; in_done <= 1'b0;
      bias <= '0; shift <= '0; byp <= 1'b0; avg <= 1'b0;
      v1 <= 1'b0; l1 <= 1'b0; ro1 <= 1'b0; co1 <= 1'b0;
      pj1 <= '0;
      v2 <= 1'b0; l2 <= 1'b0; ro2 <= 1'b0; co2 <= 1'b0;
      pj2 <= '0; acc <= '0;
      v3 <= 1'b0; l3 <= 1'b0; ro3 <= 1'b0; co3 <= 1'b0;
      pj3 <= '0; q3 <= '0;
      v4 <= 1'b0; l4 <= 1'b0; pq <= '0; hreg <= '0;
    end else begin
      if (w_acc) begin
        wt[wr][wc] <= bus.w_data;
        if (w_last) begin
          wr <= '0; wc <= '0;
        end else if (wc == KW'(K - 1)) begin
          wc <= '0; wr <= wr + KW'(1);
        end else begin
          wc <= wc + KW'(1);
        end
      end

      if (state == IDLE && bus.start) begin
        bias  <= bus.cfg_bias;
        shift <= bus.cfg_shift;
        byp   <= bus.cfg_pool_mode[1];
        avg   <= (bus.cfg_pool_mode == 2'd1);
        r <= '0; c <= '0; in_done <= 1'b0;
        for (int k = 0; k < K - 1; k++)
          for (int x = 0; x < MAP_W; x++)
            lb[k][x] <= '0;
        for (int p = 0; p < PW; p++) pbuf[p] <= '0;
        hreg <= '0;
      end else if (state == IDLE && bus.w_reload) begin
        wr <= '0; wc <= '0;
      end

      if (p_acc) begin
        lb[0][c] <= bus.pixel_in;
        for (int k = 1; k < K - 1; k++)
          lb[k][c] <= lb[k-1][c];
        for (int i = 0; i < K; i++) begin
          for (int j = 0; j < K - 1; j++)
            win[i][j] <= win[i][j+1];
          win[i][K-1] <= col[i];
        end
        if (p_last) in_done <= 1'b1;
        if (c == CW'(MAP_W - 1)) begin
          c <= '0; r <= r + RW'(1);
        end else begin
          c <= c + CW'(1);
        end
      end

      v1  <= p_acc && (r >= RW'(K - 1)) && (c >= CW'(K - 1));
      l1  <= p_acc && p_last;
      ro1 <= r[0] ^ KODD;
      co1 <= c[0] ^ KODD;
      pj1 <= PJW'((c - CW'(K - 1)) >> 1);

      v2 <= v1; l2 <= l1; ro2 <= ro1; co2 <= co1;
      pj2 <= pj1; acc <= acc_n;

      v3 <= v2; l3 <= l2; ro3 <= ro2; co3 <= co2;
      pj3 <= pj2; q3 <= q_n;

      if (v3 && !byp) begin
        if (!co3)      hreg <= qx;
        else if (!ro3) pbuf[pj3] <= pair;
      end
      v4 <= v3 && !byp && co3 && ro3;
      l4 <= v3 && !byp && l3;
      pq <= pool_n;
    end
  end
endmodule

// File: tb/tb_conv_pool_channel.sv
// Randomised self-checking bench for conv_pool_channel.
// Expected streams come from a direct conv/pool arithmetic model.
module tb_conv_pool_channel;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  conv_pool_channel_if #(.DATA_W(8), .WEIGHT_W(8), .ACC_W(32)) bus ();

  conv_pool_channel #(
    .MAP_W(8), .MAP_H(8), .K(3),
    .DATA_W(8), .WEIGHT_W(8), .ACC_W(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic signed [7:0] wts [9];
  logic signed [7:0] frame [64];
  int acc_at [64];
  logic [7:0] got [$];
  int got_cyc [$];
  logic [7:0] expq [$];
  logic [7:0] refq [$];
  int ld_cnt = 0;
  int ld_idx = -1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.out_valid) begin
      got.push_back(bus.pixel_out);
      got_cyc.push_back(cyc);
    end
    if (bus.layer_done) begin
      ld_cnt++;
      ld_idx = got.size();
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    got.delete();
    got_cyc.delete();
    ld_cnt = 0;
    ld_idx = -1;
  endtask

  function automatic void model(input int b, input int sh, input int mode);
    int q [6][6];
    longint s;
    int a, m;
    expq.delete();
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 6; j++) begin
        s = longint'(b);
        for (int u = 0; u < 3; u++)
          for (int v = 0; v < 3; v++)
            s += longint'(wts[u*3+v]) * longint'(frame[(i+u)*8+j+v]);
        a = int'(s);
        a = a >>> sh;
        q[i][j] = (a < 0) ? 0 : ((a > 127) ? 127 : a);
      end
    if (mode >= 2) begin
      for (int i = 0; i < 6; i++)
        for (int j = 0; j < 6; j++)
          expq.push_back(8'(q[i][j]));
    end else begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++) begin
          if (mode == 1) begin
            m = (q[2*i][2*j] + q[2*i][2*j+1] +
                 q[2*i+1][2*j] + q[2*i+1][2*j+1]) >> 2;
          end else begin
            m = q[2*i][2*j];
            if (q[2*i][2*j+1] > m) m = q[2*i][2*j+1];
            if (q[2*i+1][2*j] > m) m = q[2*i+1][2*j];
            if (q[2*i+1][2*j+1] > m) m = q[2*i+1][2*j+1];
          end
          expq.push_back(8'(m));
        end
    end
  endfunction

  task automatic load_w(input int gap);
    int n = 0;
    int g = 0;
    bit a;
    while (n < 9 && g < 500) begin
      bus.w_valid = ($urandom_range(0, 99) >= gap);
      bus.w_data = wts[n];
      a = bus.w_valid && bus.w_ready;
      tick();
      g++;
      if (a) n++;
    end
    bus.w_valid = 1'b0;
    if (n < 9) begin
      total++; bad++;
      $display("FAIL load_timeout got=%0d want=9", n);
    end
  endtask

  task automatic reload(input int gap);
    bus.w_reload = 1'b1;
    tick();
    bus.w_reload = 1'b0;
    load_w(gap);
  endtask

  task automatic do_start(input int b, input int sh, input int mode);
    bus.cfg_bias = b;
    bus.cfg_shift = 5'(sh);
    bus.cfg_pool_mode = 2'(mode);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic send(input int npix, input int gap, input bit noise);
    int n = 0;
    int g = 0;
    bit a;
    while (n < npix && g < 3000) begin
      bus.in_valid = (gap == 0) || ($urandom_range(0, 99) >= gap);
      bus.pixel_in = frame[n];
      bus.start = noise && (n == 20);
      bus.w_valid = noise && (n == 25 || n == 26);
      bus.w_data = 8'($urandom);
      a = bus.in_valid && bus.in_ready;
      if (a) acc_at[n] = cyc;
      tick();
      g++;
      if (a) n++;
    end
    bus.in_valid = 1'b0;
    bus.start = 1'b0;
    bus.w_valid = 1'b0;
    if (n < npix) begin
      total++; bad++;
      $display("FAIL send_timeout got=%0d want=%0d", n, npix);
    end
  endtask

  task automatic wait_out(input int n);
    int g = 0;
    while (got.size() < n && g < 500) begin
      tick();
      g++;
    end
    repeat (8) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    total++;
    if (bus.w_ready !== 1'b1) begin
      bad++; $display("FAIL rst_w_ready got=%b want=1", bus.w_ready);
    end
    total++;
    if (bus.weights_loaded !== 1'b0) begin
      bad++; $display("FAIL rst_loaded got=%b want=0", bus.weights_loaded);
    end
    total++;
    if (bus.in_ready !== 1'b0) begin
      bad++; $display("FAIL rst_in_ready got=%b want=0", bus.in_ready);
    end
    total++;
    if ({bus.out_valid, bus.layer_done, bus.pixel_out} !== 10'd0) begin
      bad++;
      $display("FAIL rst_out got=%b/%b/%0d want=0/0/0",
               bus.out_valid, bus.layer_done, bus.pixel_out);
    end
  endtask

  task automatic test_load_count();
    foreach (wts[i]) wts[i] = 8'sd1;
    load_w(30);
    total++;
    if (bus.w_ready !== 1'b0 || bus.weights_loaded !== 1'b1) begin
      bad++;
      $display("FAIL load_done w_ready=%b loaded=%b want 0/1",
               bus.w_ready, bus.weights_loaded);
    end
    foreach (frame[i]) frame[i] = 8'sd1;
    clear_obs();
    do_start(0, 0, 2);
    send(64, 0, 0);
    total++;
    if (bus.in_ready !== 1'b0) begin
      bad++; $display("FAIL count_in_ready got=%b want=0", bus.in_ready);
    end
    model(0, 0, 2);
    wait_out(expq.size());
    total++;
    if (got.size() !== 36) begin
      bad++; $display("FAIL count_n got=%0d want=36", got.size());
    end
    foreach (expq[i]) if (i < got.size()) begin
      total++;
      if (got[i] !== expq[i]) begin
        bad++; $display("FAIL count_val[%0d] got=%0d want=%0d", i, got[i], expq[i]);
      end
    end
    total++;
    if (ld_cnt !== 1 || ld_idx !== 36) begin
      bad++; $display("FAIL count_done cnt=%0d at=%0d want 1 at 36", ld_cnt, ld_idx);
    end
    if (got_cyc.size() > 0) begin
      total++;
      if (got_cyc[0] - acc_at[18] !== 3) begin
        bad++;
        $display("FAIL bypass_latency got=%0d want=3", got_cyc[0] - acc_at[18]);
      end
    end
  endtask

  task automatic test_max_pool();
    foreach (wts[i]) wts[i] = (i == 4) ? 8'sd1 : 8'sd0;
    reload(0);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        frame[r*8+c] = 8'(8 * r + c);
    clear_obs();
    do_start(0, 0, 0);
    send(64, 0, 0);
    model(0, 0, 0);
    wait_out(expq.size());
    total++;
    if (got.size() !== 9) begin
      bad++; $display("FAIL max_n got=%0d want=9", got.size());
    end
    foreach (expq[i]) if (i < got.size()) begin
      total++;
      if (got[i] !== expq[i]) begin
        bad++; $display("FAIL max_val[%0d] got=%0d want=%0d", i, got[i], expq[i]);
      end
    end
    if (got.size() > 0) begin
      total++;
      if (got[0] !== 8'd18) begin
        bad++; $display("FAIL max_first got=%0d want=18", got[0]);
      end
      total++;
      if (got_cyc[0] - acc_at[27] !== 4) begin
        bad++;
        $display("FAIL pool_latency got=%0d want=4", got_cyc[0] - acc_at[27]);
      end
    end
    total++;
    if (ld_cnt !== 1 || ld_idx !== 9) begin
      bad++; $display("FAIL max_done cnt=%0d at=%0d want 1 at 9", ld_cnt, ld_idx);
    end
  endtask

  task automatic test_avg_clamp();
    int biases [2];
    logic [7:0] want [2];
    biases[0] = 0;        want[0] = 8'd127;
    biases[1] = -1000000; want[1] = 8'd0;
    foreach (wts[i]) wts[i] = 8'sd16;
    reload(20);
    foreach (frame[i]) frame[i] = 8'sd100;
    for (int k = 0; k < 2; k++) begin
      clear_obs();
      do_start(biases[k], 4, 1);
      send(64, 0, 0);
      model(biases[k], 4, 1);
      wait_out(expq.size());
      total++;
      if (got.size() !== 9) begin
        bad++; $display("FAIL avg_n[%0d] got=%0d want=9", k, got.size());
      end
      foreach (got[i]) begin
        total++;
        if (got[i] !== want[k]) begin
          bad++; $display("FAIL avg_val[%0d][%0d] got=%0d want=%0d", k, i, got[i], want[k]);
        end
      end
    end
  endtask

  task automatic test_shift_relu();
    logic signed [7:0] cw [2];
    int sh [2];
    logic [7:0] want [2];
    cw[0] = -8'sd1; sh[0] = 0; want[0] = 8'd0;
    cw[1] = 8'sd3;  sh[1] = 1; want[1] = 8'd7;
    foreach (frame[i]) frame[i] = 8'sd5;
    for (int k = 0; k < 2; k++) begin
      foreach (wts[i]) wts[i] = (i == 4) ? cw[k] : 8'sd0;
      reload(0);
      clear_obs();
      do_start(0, sh[k], 2 + k);
      send(64, 0, 0);
      wait_out(36);
      total++;
      if (got.size() !== 36) begin
        bad++; $display("FAIL relu_n[%0d] got=%0d want=36", k, got.size());
      end
      foreach (got[i]) begin
        total++;
        if (got[i] !== want[k]) begin
          bad++; $display("FAIL relu_val[%0d][%0d] got=%0d want=%0d", k, i, got[i], want[k]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int b, sh, mode;
    for (int it = 0; it < 3; it++) begin
      foreach (wts[i]) wts[i] = 8'($urandom);
      foreach (frame[i]) frame[i] = 8'($urandom);
      reload(40);
      b = $urandom_range(0, 4000) - 2000;
      sh = $urandom_range(6, 10);
      mode = $urandom_range(0, 3);
      model(b, sh, mode);
      clear_obs();
      do_start(b, sh, mode);
      send(64, 0, 0);
      wait_out(expq.size());
      refq = got;
      clear_obs();
      do_start(b, sh, mode);
      send(64, 50, 1);
      total++;
      if (bus.in_ready !== 1'b0) begin
        bad++; $display("FAIL gap_in_ready[%0d] got=%b want=0", it, bus.in_ready);
      end
      wait_out(expq.size());
      total++;
      if (got.size() !== expq.size() || refq.size() !== expq.size()) begin
        bad++;
        $display("FAIL gap_n[%0d] got=%0d ref=%0d want=%0d",
                 it, got.size(), refq.size(), expq.size());
      end
      foreach (expq[i]) if (i < got.size() && i < refq.size()) begin
        total++;
        if (got[i] !== expq[i] || refq[i] !== expq[i]) begin
          bad++;
          $display("FAIL gap_val[%0d][%0d] got=%0d ref=%0d want=%0d",
                   it, i, got[i], refq[i], expq[i]);
        end
      end
      total++;
      if (ld_cnt !== 1) begin
        bad++; $display("FAIL gap_done[%0d] got=%0d want=1", it, ld_cnt);
      end
    end
  endtask

  task automatic test_reset_mid();
    int mode;
    foreach (frame[i]) frame[i] = 8'($urandom);
    do_start(0, 6, 2);
    send(30, 0, 0);
    rst = 1'b1;
    tick();
    total++;
    if (bus.w_ready !== 1'b1 || bus.weights_loaded !== 1'b0 ||
        bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL midrst_state w_ready=%b loaded=%b ov=%b ir=%b want 1/0/0/0",
               bus.w_ready, bus.weights_loaded, bus.out_valid, bus.in_ready);
    end
    clear_obs();
    rst = 1'b0;
    repeat (10) tick();
    total++;
    if (got.size() !== 0) begin
      bad++; $display("FAIL midrst_quiet got=%0d want=0", got.size());
    end
    foreach (wts[i]) wts[i] = 8'($urandom);
    load_w(10);
    mode = $urandom_range(0, 3);
    model(100, 7, mode);
    clear_obs();
    do_start(100, 7, mode);
    send(64, 20, 0);
    wait_out(expq.size());
    total++;
    if (got.size() !== expq.size()) begin
      bad++; $display("FAIL midrst_n got=%0d want=%0d", got.size(), expq.size());
    end
    foreach (expq[i]) if (i < got.size()) begin
      total++;
      if (got[i] !== expq[i]) begin
        bad++; $display("FAIL midrst_val[%0d] got=%0d want=%0d", i, got[i], expq[i]);
      end
    end
    bus.w_reload = 1'b1;
    tick();
    bus.w_reload = 1'b0;
    total++;
    if (bus.w_ready !== 1'b1 || bus.weights_loaded !== 1'b0) begin
      bad++;
      $display("FAIL reload_state w_ready=%b loaded=%b want 1/0",
               bus.w_ready, bus.weights_loaded);
    end
  endtask

  initial begin
    bus.w_valid = 1'b0;
    bus.w_data = '0;
    bus.w_reload = 1'b0;
    bus.cfg_bias = '0;
    bus.cfg_shift = '0;
    bus.cfg_pool_mode = '0;
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    bus.pixel_in = '0;
    test_reset();
    test_load_count();
    test_max_pool();
    test_avg_clamp();
    test_shift_relu();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
